// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared widths, opcode and FSM state encodings for multicycle_alu
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam int ALU_WIDTH = 24;
  localparam int ALU_CNT_W = 5;
  localparam int SHAMT_W   = 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SLT  = 4'd7,
    OP_MUL  = 4'd8,
    OP_DIVU = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// ============================================================================
// alu_iter_muldiv : one shift-add multiply or restoring-divide step per clock
// Revision: 1.0
// ============================================================================
module alu_iter_muldiv #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_diff;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;

    w_sum     = {1'b0, hi_q} + {1'b0, b_q};
    w_shifted = {hi_q, lo_q[WIDTH-1]};
    w_diff    = w_shifted - {1'b0, b_q};

    if (go) begin
      hi_d   = '0;
      lo_d   = a;
      b_d    = b;
      mode_d = mode;
      cnt_d  = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (!mode_q) begin
        // Multiplier sits in lo and is consumed LSB-first as the product shifts in.
        if (lo_q[0]) {hi_d, lo_d} = {w_sum, lo_q[WIDTH-1:1]};
        else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
      end else begin
        // A zero divisor never borrows, yielding all-ones quotient and remainder = A.
        if (!w_diff[WIDTH]) begin
          hi_d = w_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = w_shifted[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// multicycle_alu : execute-stage ALU, single-cycle ops plus iterative MUL/DIVU
// Revision: 1.0
// ============================================================================
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             div0,
  output logic             illegal,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             div0_q, div0_d;
  logic             illegal_q, illegal_d;
  logic             done_q, done_d;
  logic             div_mode_q, div_mode_d;
  logic             b_zero_q, b_zero_d;

  logic             w_go;
  logic             w_step;
  logic [WIDTH-1:0] w_eng_hi;
  logic [WIDTH-1:0] w_eng_lo;
  logic             w_eng_last;

  logic [WIDTH-1:0]   w_sc_res;
  logic               w_sc_ovf;
  logic               w_sc_ill;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH-1:0]   w_sub;
  logic [SHAMT_W-1:0] w_shamt;

  alu_iter_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (w_go),
    .mode  (op == OP_DIVU),
    .step  (w_step),
    .a     (BusA),
    .b     (BusB),
    .hi    (w_eng_hi),
    .lo    (w_eng_lo),
    .last  (w_eng_last)
  );

  always_comb begin
    w_sc_res = '0;
    w_sc_ovf = 1'b0;
    w_sc_ill = 1'b0;
    w_add    = BusA + BusB;
    w_sub    = BusA - BusB;
    w_shamt  = BusB[SHAMT_W-1:0];
    case (op)
      OP_ADD: begin
        w_sc_res = w_add;
        w_sc_ovf = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (w_add[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_res = w_sub;
        w_sc_ovf = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (w_sub[WIDTH-1] != BusA[WIDTH-1]);
      end
      OP_AND:  w_sc_res = BusA & BusB;
      OP_OR:   w_sc_res = BusA | BusB;
      OP_XOR:  w_sc_res = BusA ^ BusB;
      OP_SLL:  w_sc_res = (w_shamt >= SHAMT_W'(WIDTH)) ? '0 : (BusA << w_shamt);
      OP_SRL:  w_sc_res = (w_shamt >= SHAMT_W'(WIDTH)) ? '0 : (BusA >> w_shamt);
      OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(BusA) < $signed(BusB))};
      OP_MUL, OP_DIVU: w_sc_res = '0;
      default: w_sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    div0_d      = div0_q;
    illegal_d   = illegal_q;
    div_mode_d  = div_mode_q;
    b_zero_d    = b_zero_q;
    done_d      = 1'b0;
    w_go        = 1'b0;
    w_step      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_iterative(op)) begin
            w_go       = 1'b1;
            div_mode_d = (op == OP_DIVU);
            b_zero_d   = (BusB == '0);
            state_d    = ITER;
          end else begin
            result_d    = w_sc_res;
            result_hi_d = '0;
            zero_d      = (w_sc_res == '0);
            neg_d       = w_sc_res[WIDTH-1];
            ovf_d       = w_sc_ovf;
            div0_d      = 1'b0;
            illegal_d   = w_sc_ill;
            done_d      = 1'b1;
          end
        end
      end
      ITER: begin
        w_step = 1'b1;
        if (w_eng_last) state_d = FIN;
      end
      FIN: begin
        result_d    = w_eng_lo;
        result_hi_d = w_eng_hi;
        zero_d      = (w_eng_lo == '0);
        neg_d       = w_eng_lo[WIDTH-1];
        ovf_d       = 1'b0;
        div0_d      = div_mode_q && b_zero_q;
        illegal_d   = 1'b0;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      illegal_q   <= 1'b0;
      done_q      <= 1'b0;
      div_mode_q  <= 1'b0;
      b_zero_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
      illegal_q   <= illegal_d;
      done_q      <= done_d;
      div_mode_q  <= div_mode_d;
      b_zero_q    <= b_zero_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign div0      = div0_q;
  assign illegal   = illegal_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/multicycle_alu.md
# multicycle_alu

Execute-stage ALU of the 24-bit multicycle MIPS datapath, directly downstream of the register file: it consumes the registered BusA/BusB operands and produces the value that returns to the register file on BusW. Single-cycle logic/arithmetic ops complete in one clock. Multiply and divide run as a 24-iteration shift-add / restoring-divide engine behind a start/busy/done handshake, so the control FSM can stall on them.

## Interface
- WIDTH, 24, operand/result width (matches BusA/BusB/BusW)
- CNT_W, 5, iteration counter width (ceil(log2(WIDTH+1)))
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  operation request, sampled only when busy=0
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT, 8 MUL, 9 DIVU; 10-15 illegal
- BusA  in  WIDTH  operand A (from register file)
- BusB  in  WIDTH  operand B (from register file)
- result  out  WIDTH  primary result (low product / quotient)
- result_hi  out  WIDTH  high product / remainder; 0 for single-cycle ops
- zero  out  1  result == 0
- neg  out  1  result[WIDTH-1]
- ovf  out  1  signed overflow, ADD/SUB only; else 0
- div0  out  1  DIVU with BusB == 0
- illegal  out  1  opcode 10-15
- busy  out  1  iterative op in progress
- done  out  1  one-cycle pulse, outputs valid

## Operation
- Reset (async, rst_n=0): state IDLE, counter 0, result/result_hi 0, all flags 0, busy 0, done 0.
- States: IDLE, ITER, FIN. Operands and op captured at the accepting edge; BusA/BusB may change afterwards.
- IDLE, start=1, op single-cycle or illegal: compute, register outputs, done=1 next cycle, stay IDLE.
- IDLE, start=1, op MUL/DIVU: load A/B into working regs, counter=0, busy=1, go ITER.
- ITER: one iteration per clock; after iteration WIDTH-1, go FIN.
- FIN: write result/result_hi/flags, done=1, busy=0, go IDLE.
- start while busy: ignored, no queueing.
- ADD/SUB: modulo 2^WIDTH; ovf = operand signs equal (SUB: A vs ~B) and result sign differs.
- SLL/SRL: amount BusB[4:0]; amount ≥ WIDTH gives 0. SRL logical.
- SLT: signed compare, result 1 or 0.
- MUL: unsigned 24x24 → 48 bits; result = low, result_hi = high.
- DIVU: unsigned restoring; result = quotient, result_hi = remainder.
- DIVU by 0: result = all ones, result_hi = BusA, div0=1; still full latency.
- illegal: result 0, result_hi 0, illegal=1, done pulse.
- Outputs and flags hold between done pulses; flags not named in an op's rule are 0.

## Timing
- Accepting edge E0 (start=1, busy=0).
- Single-cycle ops: outputs valid and done=1 in the cycle after E0; busy never rises.
- MUL/DIVU: busy=1 from after E0 through FIN; iterations at E1..E24, FIN transition at E24, outputs written and done=1 after E25.
- Iterative latency is fixed at WIDTH+1 = 25 cycles, data independent.
- done=1 after the final edge; a new start in that same cycle is accepted (busy already 0).
- Reset mid-ITER: immediate abort, all outputs to reset values, no done pulse.

## Structure
- Package alu_pkg: WIDTH, opcode enum (OP_ADD..OP_DIVU), state enum (IDLE/ITER/FIN).
- Sub-module alu_iter_muldiv: working regs, counter, one shift-add or restore step per clock; exposes go/mode/step/hi/lo.
- The top contains the combinational single-cycle path, FSM and output registers.

## Test plan
- ADD 0x7FFFFF + 0x000001 → result 0x800000, ovf=1, neg=1, done one cycle after start.
- SUB 0x000100 − 0x000100 → result 0, zero=1; SLL 0x000001 by 23 → 0x800000; by 24 → 0.
- MUL 0x001000 × 0x001000 → result 0x000000, result_hi 0x000001; done exactly 25 cycles after start; start pulses while busy ignored.
- DIVU 0x100000 / 0x000003 → result 0x055555, result_hi 0x000001; DIVU 0x000010 / 0 → result 0xFFFFFF, result_hi 0x000010, div0=1.
- SLT 0xFFFFFF vs 0x000001 → 1; op=12 → result 0, illegal=1, done pulse.
- rst_n low at iteration 10 of MUL → all outputs 0 immediately, no done pulse; next ADD completes normally.
